// File: rtl/lbp_nway.sv
// lbp_nway: parametrised local branch predictor covering every lane of a fetch block.
//
// A per-lane local history table (LHT) gives a history for each lane of the addressed row.
// That history indexes a per-lane pattern table (PHT) of saturating counters. The predicted
// direction is the counter MSB. After reset or flush, a sweep FSM writes both tables with
// their initial values. An update and a lookup in the same cycle are resolved write-first.
//
// Ports
//   clk_i         : clock
//   rst_i         : synchronous active-high reset (forces the INIT sweep from idx 0)
//   flush_bp_i    : restarts the INIT sweep from the next cycle
//   debug_mode_i  : drops updates while high
//   vpc_i         : lookup PC (fetch-block aligned)
//   ready_o       : tables initialised (registered)
//   pred_valid_o  : per-lane prediction valid (one cycle after the lookup)
//   pred_taken_o  : per-lane predicted direction
//   pred_hist_o   : per-lane history used, lane l at [l*HIST_BITS +: HIST_BITS]
//   upd_valid_i   : resolved-branch update strobe
//   upd_pc_i      : resolved-branch PC
//   upd_taken_i   : resolved direction
//   upd_hist_i    : history returned from pred_hist_o for this branch's lane
module lbp_nway #(
  parameter int unsigned VLEN            = 32,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned LHT_ENTRIES     = 64,
  parameter int unsigned HIST_BITS       = 8,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned OFFSET          = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_bp_i,
  input  logic                                 debug_mode_i,
  input  logic [VLEN-1:0]                      vpc_i,
  output logic                                 ready_o,
  output logic [INSTR_PER_FETCH-1:0]           pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0]           pred_taken_o,
  output logic [INSTR_PER_FETCH*HIST_BITS-1:0] pred_hist_o,
  input  logic                                 upd_valid_i,
  input  logic [VLEN-1:0]                      upd_pc_i,
  input  logic                                 upd_taken_i,
  input  logic [HIST_BITS-1:0]                 upd_hist_i
);

  localparam int unsigned IPF        = INSTR_PER_FETCH;
  localparam int unsigned NR_ROWS    = LHT_ENTRIES / IPF;
  localparam int unsigned PHT_SIZE   = 1 << HIST_BITS;
  localparam int unsigned N_SWEEP    = (NR_ROWS > PHT_SIZE) ? NR_ROWS : PHT_SIZE;
  localparam int unsigned LANE_SHIFT = (IPF > 1) ? $clog2(IPF) : 0;
  localparam int unsigned LANE_W     = (IPF > 1) ? $clog2(IPF) : 1;
  localparam int unsigned ROW_W      = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1;
  localparam int unsigned IDX_W      = $clog2(N_SWEEP);

  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(N_SWEEP - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN     = {CTR_BITS{1'b0}};
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Saturating +/-1 on a pattern-table counter.
  function automatic logic [CTR_BITS-1:0] ctr_sat(input logic [CTR_BITS-1:0] ctr,
                                                   input logic taken);
    logic [CTR_BITS-1:0] res;
    if (taken) begin
      res = (ctr == CTR_MAX) ? ctr : ctr + {{(CTR_BITS-1){1'b0}}, 1'b1};
    end else begin
      res = (ctr == CTR_MIN) ? ctr : ctr - {{(CTR_BITS-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // Storage: the tables have no reset; the INIT sweep gives them defined contents.
  logic [HIST_BITS-1:0] lht_q [NR_ROWS][IPF];
  logic [CTR_BITS-1:0]  pht_q [IPF][PHT_SIZE];

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 ready_q;
  logic [IPF-1:0]       pred_valid_q;
  logic [IPF-1:0]       pred_taken_q;
  logic [IPF*HIST_BITS-1:0] pred_hist_q;

  logic [ROW_W-1:0]     lk_row_s;
  logic [IPF-1:0]       lk_taken_s;
  logic [IPF*HIST_BITS-1:0] lk_hist_s;

  logic                 upd_en_s;
  logic [ROW_W-1:0]     upd_row_s;
  logic [LANE_W-1:0]    upd_lane_s;
  logic [HIST_BITS-1:0] upd_lht_new_s;
  logic [CTR_BITS-1:0]  upd_ctr_new_s;
  logic                 lint_unused_s;

  // Only the row/lane fields of the PCs are used.
  assign lint_unused_s = ^{vpc_i, upd_pc_i};

  // Address decode of the lookup and update PCs.
  assign lk_row_s   = (NR_ROWS > 1) ? vpc_i[OFFSET+LANE_SHIFT +: ROW_W] : {ROW_W{1'b0}};
  assign upd_row_s  = (NR_ROWS > 1) ? upd_pc_i[OFFSET+LANE_SHIFT +: ROW_W] : {ROW_W{1'b0}};
  assign upd_lane_s = (IPF > 1) ? upd_pc_i[OFFSET +: LANE_W] : {LANE_W{1'b0}};

  // An update commits only in READY. Reset, flush and debug mode all suppress it.
  assign upd_en_s = upd_valid_i & ~debug_mode_i & ~flush_bp_i & ~rst_i & (state_q == ST_READY);

  // Post-update values, shared by the table write and the write-first bypass.
  assign upd_lht_new_s = {lht_q[upd_row_s][upd_lane_s][HIST_BITS-2:0], upd_taken_i};
  assign upd_ctr_new_s = ctr_sat(pht_q[upd_lane_s][upd_hist_i], upd_taken_i);

  // Lookup of every lane. A same-cycle update to the same LHT slot or PHT entry is forwarded.
  always_comb begin
    logic [HIST_BITS-1:0] hist_v;
    logic [CTR_BITS-1:0]  ctr_v;
    lk_taken_s = {IPF{1'b0}};
    lk_hist_s  = {(IPF*HIST_BITS){1'b0}};
    for (int l = 0; l < int'(IPF); l++) begin
      hist_v = (upd_en_s && (upd_row_s == lk_row_s) && (upd_lane_s == LANE_W'(l)))
             ? upd_lht_new_s : lht_q[lk_row_s][LANE_W'(l)];
      // The PHT bypass compares against the history this lane actually uses, which may
      // already be the forwarded value.
      ctr_v  = (upd_en_s && (upd_lane_s == LANE_W'(l)) && (upd_hist_i == hist_v))
             ? upd_ctr_new_s : pht_q[LANE_W'(l)][hist_v];
      lk_hist_s[l*HIST_BITS +: HIST_BITS] = hist_v;
      lk_taken_s[l]                       = ctr_v[CTR_BITS-1];
    end
  end

  // Table writes: sweep initialisation in INIT, training updates in READY.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      for (int l = 0; l < int'(IPF); l++) begin
        // The sweep runs to max(rows, PHT size), so each table is written only while idx is in range.
        if (int'(idx_q) < int'(NR_ROWS)) begin
          lht_q[idx_q[ROW_W-1:0]][LANE_W'(l)] <= {HIST_BITS{1'b0}};
        end
        if (int'(idx_q) < int'(PHT_SIZE)) begin
          pht_q[LANE_W'(l)][idx_q[HIST_BITS-1:0]] <= CTR_WEAK_NT;
        end
      end
    end else if (upd_en_s) begin
      lht_q[upd_row_s][upd_lane_s] <= upd_lht_new_s;
      pht_q[upd_lane_s][upd_hist_i] <= upd_ctr_new_s;
    end
  end

  // Sweep FSM: INIT walks idx over the sweep range, then the FSM stays in READY until a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      idx_q   <= {IDX_W{1'b0}};
      ready_q <= 1'b0;
    end else if (flush_bp_i) begin
      state_q <= ST_INIT;
      idx_q   <= {IDX_W{1'b0}};
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (idx_q == IDX_LAST) begin
            state_q <= ST_READY;
            idx_q   <= {IDX_W{1'b0}};
            ready_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            ready_q <= 1'b0;
          end
        end
        ST_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          idx_q   <= {IDX_W{1'b0}};
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Prediction outputs are registered one cycle after the lookup and zeroed outside READY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_q <= {IPF{1'b0}};
      pred_taken_q <= {IPF{1'b0}};
      pred_hist_q  <= {(IPF*HIST_BITS){1'b0}};
    end else if (state_q == ST_READY) begin
      pred_valid_q <= {IPF{1'b1}};
      pred_taken_q <= lk_taken_s;
      pred_hist_q  <= lk_hist_s;
    end else begin
      pred_valid_q <= {IPF{1'b0}};
      pred_taken_q <= {IPF{1'b0}};
      pred_hist_q  <= {(IPF*HIST_BITS){1'b0}};
    end
  end

  assign ready_o      = ready_q;
  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_hist_o  = pred_hist_q;

endmodule

// File: tb/tb_lbp_nway.sv
// Directed bench for lbp_nway with default parameters (2 lanes, 32 rows, 8-bit history, 2-bit counters).
// Stimulus pushes the expected prediction for each lookup into a queue. A monitor pops the
// queue and compares one cycle later.
module tb_lbp_nway;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_bp_i;
  logic        debug_mode_i;
  logic [31:0] vpc_i;
  logic        ready_o;
  logic [1:0]  pred_valid_o;
  logic [1:0]  pred_taken_o;
  logic [15:0] pred_hist_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [7:0]  upd_hist_i;

  always #5 clk_i = ~clk_i;

  lbp_nway dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_bp_i   (flush_bp_i),
    .debug_mode_i (debug_mode_i),
    .vpc_i        (vpc_i),
    .ready_o      (ready_o),
    .pred_valid_o (pred_valid_o),
    .pred_taken_o (pred_taken_o),
    .pred_hist_o  (pred_hist_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_hist_i   (upd_hist_i)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  taken;
    logic [15:0] hist;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic lk_tag = 1'b0;
  logic chk_due = 1'b0;

  // Remember which cycles carried a lookup, so their results are checked one cycle later.
  always @(posedge clk_i) chk_due <= lk_tag;

  // Monitor: compare registered predictions against the scoreboard.
  always @(negedge clk_i) begin
    if (chk_due) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: prediction with no expected entry");
      end else begin
        mon_e = exp_q.pop_front();
        if ({pred_valid_o, pred_taken_o, pred_hist_o} !== {mon_e.valid, mon_e.taken, mon_e.hist}) begin
          errors++;
          $display("FAIL %s: got valid=%b taken=%b hist=%h, expected valid=%b taken=%b hist=%h",
                   mon_e.name, pred_valid_o, pred_taken_o, pred_hist_o,
                   mon_e.valid, mon_e.taken, mon_e.hist);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
    lk_tag      = 1'b0;
    upd_valid_i = 1'b0;
    flush_bp_i  = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [1:0] taken,
                        input logic [7:0] h0, input logic [7:0] h1, input string name);
    exp_t e;
    vpc_i   = pc;
    lk_tag  = 1'b1;
    e.valid = 2'b11;
    e.taken = taken;
    e.hist  = {h1, h0};
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [7:0] h);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = taken;
    upd_hist_i  = h;
  endtask

  // Count cycles until ready_o rises. If inject_at >= 0, also issue an update in that cycle.
  task automatic wait_ready(input string name, input int inject_at);
    int cnt = 0;
    while (ready_o !== 1'b1 && cnt < 400) begin
      if (cnt == inject_at) upd(32'h104, 1'b1, 8'h00);
      if (cnt == 5) check({name, "_valid_low"}, {30'd0, pred_valid_o}, 32'd0);
      tick();
      cnt++;
    end
    check(name, cnt, 32'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; flush_bp_i = 1'b0; debug_mode_i = 1'b0; vpc_i = 32'h0;
    upd_valid_i = 1'b0; upd_pc_i = 32'h0; upd_taken_i = 1'b0; upd_hist_i = 8'h00;
    repeat (3) tick();
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_valid", {30'd0, pred_valid_o}, 32'd0);
    check("rst_taken", {30'd0, pred_taken_o}, 32'd0);
    check("rst_hist", {16'd0, pred_hist_o}, 32'd0);
    rst_i = 1'b0;
    wait_ready("init_ready", -1);

    lookup(32'h104, 2'b00, 8'h00, 8'h00, "init_lookup"); tick();

    // Train PHT[0][0] with five taken updates. LHT[1][0] goes 0->1F and PHT[0][0] goes 1->3, saturated.
    repeat (5) begin upd(32'h104, 1'b1, 8'h00); tick(); end
    lookup(32'h104, 2'b00, 8'h1F, 8'h00, "train_hist"); tick();
    lookup(32'h108, 2'b01, 8'h00, 8'h00, "train_taken"); tick();
    // One not-taken update: a saturated counter goes 3->2 (still taken). A wrapped counter would not.
    upd(32'h104, 1'b0, 8'h00); tick();
    lookup(32'h108, 2'b01, 8'h00, 8'h00, "sat_no_wrap"); tick();
    repeat (4) begin upd(32'h104, 1'b0, 8'h00); tick(); end
    lookup(32'h108, 2'b00, 8'h00, 8'h00, "floor"); tick();
    // From a clamped 0, two taken updates give 2 (taken).
    repeat (2) begin upd(32'h104, 1'b1, 8'h00); tick(); end
    lookup(32'h108, 2'b01, 8'h00, 8'h00, "no_underflow"); tick();
    lookup(32'h104, 2'b00, 8'h83, 8'h00, "hist_shift"); tick();

    // PHT bypass: a row-3 lane-1 update moves PHT[1][0] from 1 to 2 in the same cycle as the row-2 lookup.
    upd(32'h10E, 1'b1, 8'h00);
    lookup(32'h108, 2'b11, 8'h00, 8'h00, "bypass_pht"); tick();
    // LHT bypass: the row-1 lane-1 history becomes 01 in the same cycle as the lookup.
    upd(32'h106, 1'b1, 8'h00);
    lookup(32'h104, 2'b00, 8'h83, 8'h01, "bypass_lht"); tick();

    // Debug mode: both updates are dropped.
    debug_mode_i = 1'b1;
    upd(32'h104, 1'b1, 8'h00); tick();
    upd(32'h108, 1'b0, 8'h00); tick();
    debug_mode_i = 1'b0;
    lookup(32'h104, 2'b00, 8'h83, 8'h01, "debug_lht"); tick();
    lookup(32'h108, 2'b11, 8'h00, 8'h00, "debug_pht"); tick();

    // Flush together with an update; a second update is issued late in the sweep.
    upd(32'h104, 1'b1, 8'h00);
    flush_bp_i = 1'b1;
    tick();
    check("flush_ready_low", {31'd0, ready_o}, 32'd0);
    wait_ready("flush_ready", 250);
    lookup(32'h104, 2'b00, 8'h00, 8'h00, "flush_clear_104"); tick();
    lookup(32'h108, 2'b00, 8'h00, 8'h00, "flush_clear_108"); tick();
    lookup(32'h10C, 2'b00, 8'h00, 8'h00, "flush_clear_10c"); tick();

    // Retrain, then reset at sweep idx 100: the sweep restarts from 0.
    upd(32'h104, 1'b1, 8'h00); tick();
    flush_bp_i = 1'b1;
    tick();
    repeat (100) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_ready_low", {31'd0, ready_o}, 32'd0);
    wait_ready("rst_mid_ready", -1);
    lookup(32'h104, 2'b00, 8'h00, 8'h00, "rst_mid_clear"); tick();
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
